// File: rtl/sysid_pkg.sv
// System-ID register file: shared register offsets and CTRL bits.
// Also holds the byte-lane merge used by writable registers.
package sysid_pkg;

  localparam logic [2:0] ADDR_SYSTEM_ID = 3'd0;
  localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
  localparam logic [2:0] ADDR_SCRATCH   = 3'd2;
  localparam logic [2:0] ADDR_UPTIME_LO = 3'd3;
  localparam logic [2:0] ADDR_HI_SHADOW = 3'd4;
  localparam logic [2:0] ADDR_SECONDS   = 3'd5;
  localparam logic [2:0] ADDR_CTRL      = 3'd6;

  localparam int CTRL_CLEAR  = 0;
  localparam int CTRL_FREEZE = 1;

  function automatic logic [31:0] be_merge(
    input logic [31:0] old,
    input logic [31:0] wdata,
    input logic [3:0]  be
  );
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sysid_regfile_if.sv
// Avalon-MM slave bundle for the system-ID register file.
// No waitrequest: every strobe is accepted the cycle it is seen.
interface sysid_regfile_if;

  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, write,
    output writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write,
    input  writedata, byteenable,
    output readdata, readdatavalid
  );

endinterface

// File: rtl/sysid_uptime_counter.sv
// 64-bit uptime counter plus prescaled 32-bit seconds counter.
// Clear beats increment; freeze holds every counter.
module sysid_uptime_counter #(
  parameter int CLK_FREQ_HZ = 50000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        freeze,
  output logic [63:0] uptime,
  output logic [31:0] seconds
);

  localparam int PW = $clog2(CLK_FREQ_HZ);
  localparam logic [PW-1:0] TERM = PW'(CLK_FREQ_HZ - 1);

  logic [PW-1:0] presc;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      uptime  <= '0;
      presc   <= '0;
      seconds <= '0;
    end else if (!freeze) begin
      uptime <= uptime + 64'd1;
      if (presc == TERM) begin
        presc   <= '0;
        seconds <= seconds + 32'd1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sysid_regfile.sv
// Avalon-MM system-ID slave: ID words, scratch, uptime/seconds,
// control, and a fixed one-cycle registered read path.
module sysid_regfile
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID     = 32'd1366644622,
  parameter logic [31:0] TIMESTAMP     = 32'd0,
  parameter int          CLK_FREQ_HZ   = 50000000,
  parameter logic [31:0] SCRATCH_RESET = 32'h0
) (
  input  logic            clock,
  input  logic            reset,
  sysid_regfile_if.slave  bus
);

  logic [63:0] uptime;
  logic [31:0] seconds;
  logic [31:0] scratch;
  logic [31:0] hi_shadow;
  logic [31:0] rdata;
  logic        freeze;
  logic        wr_ctrl;
  logic        clear;
  logic        wr_scratch;
  logic        rd_lo;

  assign wr_ctrl    = bus.write && (bus.address == ADDR_CTRL)
                   && bus.byteenable[0];
  assign clear      = wr_ctrl && bus.writedata[CTRL_CLEAR];
  assign wr_scratch = bus.write && (bus.address == ADDR_SCRATCH);
  assign rd_lo      = bus.read && (bus.address == ADDR_UPTIME_LO);

  sysid_uptime_counter #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ)
  ) u_counter (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear),
    .freeze  (freeze),
    .uptime  (uptime),
    .seconds (seconds)
  );

  always_comb begin
    rdata = '0;
    case (bus.address)
      ADDR_SYSTEM_ID: rdata = SYSTEM_ID;
      ADDR_TIMESTAMP: rdata = TIMESTAMP;
      ADDR_SCRATCH:   rdata = scratch;
      ADDR_UPTIME_LO: rdata = uptime[31:0];
      ADDR_HI_SHADOW: rdata = hi_shadow;
      ADDR_SECONDS:   rdata = seconds;
      ADDR_CTRL:      rdata[CTRL_FREEZE] = freeze;
      default:        rdata = '0;
    endcase
  end

  // LO read and HI capture use the same pre-increment uptime sample
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.readdata      <= '0;
      bus.readdatavalid <= 1'b0;
      scratch           <= SCRATCH_RESET;
      hi_shadow         <= '0;
      freeze            <= 1'b0;
    end else begin
      bus.readdatavalid <= bus.read;
      bus.readdata      <= bus.read ? rdata : '0;
      if (wr_scratch)
        scratch <= be_merge(scratch, bus.writedata,
                            bus.byteenable);
      if (wr_ctrl)
        freeze <= bus.writedata[CTRL_FREEZE];
      if (rd_lo)
        hi_shadow <= uptime[63:32];
    end
  end

endmodule
